// File: rtl/wb_pkg.sv
// Shared definitions for the writeback unit: load funct3 codes, FSM states
// and the decode helpers used on the accept path.
package wb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

  function automatic logic funct3_legal(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: funct3_legal = 1'b1;
      default:                             funct3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      F3_LH, F3_LHU: load_misaligned = addr_lo[0];
      F3_LW:         load_misaligned = (addr_lo != 2'b00);
      default:       load_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_unit_load_align.sv
// Combinational load data alignment: selects the byte/half/word addressed by
// addr_lo and sign- or zero-extends it according to funct3.
module load_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] result
);
  import wb_pkg::*;

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select, then extension by load type.
  always_comb begin
    byte_s = rdata[{addr_lo, 3'b000} +: 8];
    half_s = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   result = {{24{byte_s[7]}}, byte_s};
      F3_LBU:  result = {24'h00_0000, byte_s};
      F3_LH:   result = {{16{half_s[15]}}, half_s};
      F3_LHU:  result = {16'h0000, half_s};
      F3_LW:   result = rdata;
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback unit: ALU results are written one cycle after acceptance; loads
// wait in WAIT_MEM for a memory response (bounded by TIMEOUT) before writing.
module wb_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] in_result,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        pending_valid,
  output logic [4:0]  pending_rd,
  output logic        misalign_err,
  output logic        funct3_err,
  output logic        timeout_err
);
  import wb_pkg::*;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  wb_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  addr_q, addr_d;
  logic        rf_wen_q, rf_wen_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        pend_valid_q, pend_valid_d;
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic        mis_err_q, mis_err_d;
  logic        f3_err_q, f3_err_d;
  logic        to_err_q, to_err_d;
  logic        accept_s;
  logic        load_ok_s;
  logic [31:0] load_data_s;

  load_align u_align (
    .funct3  (f3_q),
    .addr_lo (addr_q),
    .rdata   (mem_rdata),
    .result  (load_data_s)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign accept_s  = in_valid && in_ready;
  assign load_ok_s = in_is_load && funct3_legal(in_funct3) && !load_misaligned(in_funct3, in_addr_lo);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: a response or the last allowed wait cycle both end WAIT_MEM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && load_ok_s) state_d = ST_WAIT_MEM;
        else                       state_d = ST_IDLE;
      end
      ST_WAIT_MEM: begin
        if (mem_rvalid || (cnt_q == CNT_LAST)) state_d = ST_IDLE;
        else                                   state_d = ST_WAIT_MEM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath: write pulses, load context latch, sticky errors.
  always_comb begin
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    mis_err_d  = mis_err_q;
    f3_err_d   = f3_err_q;
    to_err_d   = to_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && !in_is_load) begin
          rf_wen_d   = (in_rd != 5'd0);
          rf_waddr_d = in_rd;
          rf_wdata_d = in_result;
        end else if (accept_s && !funct3_legal(in_funct3)) begin
          f3_err_d = 1'b1;
        end else if (accept_s && load_misaligned(in_funct3, in_addr_lo)) begin
          mis_err_d = 1'b1;
        end else if (accept_s) begin
          cnt_d  = 8'd0;
          rd_d   = in_rd;
          f3_d   = in_funct3;
          addr_d = in_addr_lo;
        end else begin
          cnt_d = 8'd0;
        end
      end
      ST_WAIT_MEM: begin
        if (mem_rvalid) begin
          rf_wen_d   = (rd_q != 5'd0);
          rf_waddr_d = rd_q;
          rf_wdata_d = load_data_s;
        end else if (cnt_q == CNT_LAST) begin
          to_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        cnt_d = 8'd0;
      end
    endcase
    pend_valid_d = (state_d == ST_WAIT_MEM);
    pend_rd_d    = pend_valid_d ? rd_d : 5'd0;
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= 8'd0;
      rd_q         <= 5'd0;
      f3_q         <= 3'd0;
      addr_q       <= 2'd0;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= 5'd0;
      rf_wdata_q   <= 32'h0000_0000;
      pend_valid_q <= 1'b0;
      pend_rd_q    <= 5'd0;
      mis_err_q    <= 1'b0;
      f3_err_q     <= 1'b0;
      to_err_q     <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      rd_q         <= rd_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      pend_valid_q <= pend_valid_d;
      pend_rd_q    <= pend_rd_d;
      mis_err_q    <= mis_err_d;
      f3_err_q     <= f3_err_d;
      to_err_q     <= to_err_d;
    end
  end

  assign rf_wen        = rf_wen_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign pending_valid = pend_valid_q;
  assign pending_rd    = pend_rd_q;
  assign misalign_err  = mis_err_q;
  assign funct3_err    = f3_err_q;
  assign timeout_err   = to_err_q;

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: transaction-level model plus directed
// vectors with hand-computed expectations.
module tb_wb_unit;
  localparam int TMO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = 5'd0;
  logic        in_is_load = 1'b0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [1:0]  in_addr_lo = 2'd0;
  logic [31:0] in_result = 32'h0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pending_valid;
  logic [4:0]  pending_rd;
  logic        misalign_err, funct3_err, timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  wb_unit #(.TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_is_load(in_is_load), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .in_result(in_result), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending_valid(pending_valid), .pending_rd(pending_rd),
    .misalign_err(misalign_err), .funct3_err(funct3_err), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int access_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'd0)      return 1;
    else if (f3[1:0] == 2'd1) return 2;
    else                      return 4;
  endfunction

  function automatic bit is_bad_f3(input logic [2:0] f3);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] d);
    int nb;
    logic [31:0] mask, raw;
    nb   = access_bytes(f3);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    raw  = (d >> (8 * int'(a))) & mask;
    if (!f3[2] && nb < 4 && (((raw >> (8 * nb - 1)) & 32'd1) == 32'd1)) raw = raw | ~mask;
    return raw;
  endfunction

  bit          m_wait = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic [2:0]  m_f3 = 3'd0;
  logic [1:0]  m_addr = 2'd0;
  int          m_cycles = 0;
  bit          e_wen = 1'b0, e_mis = 1'b0, e_f3e = 1'b0, e_to = 1'b0;
  logic [4:0]  e_waddr = 5'd0;
  logic [31:0] e_wdata = 32'h0;

  always @(posedge clock) begin
    if (reset) begin
      m_wait <= 1'b0; m_rd <= 5'd0; m_cycles <= 0;
      e_wen <= 1'b0; e_waddr <= 5'd0; e_wdata <= 32'h0;
      e_mis <= 1'b0; e_f3e <= 1'b0; e_to <= 1'b0;
    end else begin
      e_wen <= 1'b0;
      if (!m_wait) begin
        if (in_valid) begin
          if (!in_is_load) begin
            if (in_rd != 5'd0) begin
              e_wen <= 1'b1; e_waddr <= in_rd; e_wdata <= in_result;
            end
          end else if (is_bad_f3(in_funct3)) begin
            e_f3e <= 1'b1;
          end else if ((int'(in_addr_lo) % access_bytes(in_funct3)) != 0) begin
            e_mis <= 1'b1;
          end else begin
            m_wait <= 1'b1; m_rd <= in_rd; m_f3 <= in_funct3; m_addr <= in_addr_lo;
            m_cycles <= 0;
          end
        end
      end else begin
        if (mem_rvalid) begin
          m_wait <= 1'b0;
          if (m_rd != 5'd0) begin
            e_wen <= 1'b1; e_waddr <= m_rd; e_wdata <= model_load(m_f3, m_addr, mem_rdata);
          end
        end else if (m_cycles + 1 == TMO) begin
          m_wait <= 1'b0; e_to <= 1'b1;
        end else begin
          m_cycles <= m_cycles + 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(!m_wait));
      check("rf_wen", 32'(rf_wen), 32'(e_wen));
      if (e_wen) begin
        check("rf_waddr", 32'(rf_waddr), 32'(e_waddr));
        check("rf_wdata", rf_wdata, e_wdata);
      end
      check("pending_valid", 32'(pending_valid), 32'(m_wait));
      check("pending_rd", 32'(pending_rd), m_wait ? 32'(m_rd) : 32'd0);
      check("misalign_err", 32'(misalign_err), 32'(e_mis));
      check("funct3_err", 32'(funct3_err), 32'(e_f3e));
      check("timeout_err", 32'(timeout_err), 32'(e_to));
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic v, input logic [4:0] rd, input logic ld,
                        input logic [2:0] f3, input logic [1:0] a, input logic [31:0] res);
    in_valid = v; in_rd = rd; in_is_load = ld; in_funct3 = f3; in_addr_lo = a; in_result = res;
  endtask

  task automatic issue_one(input logic [4:0] rd, input logic ld, input logic [2:0] f3,
                           input logic [1:0] a, input logic [31:0] res);
    set_in(1'b1, rd, ld, f3, a, res);
    @(posedge clock); #1;
    set_in(1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'h0);
    @(negedge clock);
  endtask

  task automatic run_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] a,
                          input logic [31:0] data, input int nwait, input bit respond,
                          output int pend);
    pend = 0;
    set_in(1'b1, rd, 1'b1, f3, a, 32'h0);
    @(posedge clock); #1;
    set_in(1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'h0);
    for (int k = 1; k <= nwait; k++) begin
      @(negedge clock);
      if (pending_valid) pend++;
      if (respond && k == nwait) begin
        mem_rvalid = 1'b1; mem_rdata = data;
      end
      @(posedge clock); #1;
      mem_rvalid = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int pend;
    logic [31:0] data_tbl [4];
    data_tbl[0] = 32'hA5A5_0001; data_tbl[1] = 32'h0000_0002;
    data_tbl[2] = 32'hFFFF_FFFF; data_tbl[3] = 32'h7654_3210;

    do_reset();
    chk_en = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_rf_wen", 32'(rf_wen), 32'd0);
    check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_pending", {26'd0, pending_valid, pending_rd}, 32'd0);
    check("rst_errs", {29'd0, misalign_err, funct3_err, timeout_err}, 32'd0);

    issue_one(5'd5, 1'b0, 3'd0, 2'd0, 32'h1234_5678);
    check("alu_wen", 32'(rf_wen), 32'd1);
    check("alu_waddr", 32'(rf_waddr), 32'd5);
    check("alu_wdata", rf_wdata, 32'h1234_5678);
    issue_one(5'd0, 1'b0, 3'd0, 2'd0, 32'hCAFE_0000);
    check("alu_rd0_wen", 32'(rf_wen), 32'd0);

    // Four back-to-back ALU ops, one write per cycle.
    set_in(1'b1, 5'd1, 1'b0, 3'd0, 2'd0, data_tbl[0]);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (i < 3) set_in(1'b1, 5'(i + 2), 1'b0, 3'd0, 2'd0, data_tbl[i + 1]);
      else       set_in(1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'h0);
      @(negedge clock);
      check("b2b_wen", 32'(rf_wen), 32'd1);
      check("b2b_waddr", 32'(rf_waddr), 32'(i + 1));
      check("b2b_wdata", rf_wdata, data_tbl[i]);
    end

    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    @(posedge clock); #1; mem_rvalid = 1'b0;
    @(negedge clock);
    check("idle_rvalid_wen", 32'(rf_wen), 32'd0);

    run_load(5'd3, 3'b000, 2'd2, 32'h0080_0000, 3, 1'b1, pend);
    check("lb_pend_cycles", 32'(pend), 32'd3);
    check("lb_waddr", 32'(rf_waddr), 32'd3);
    check("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    run_load(5'd3, 3'b100, 2'd2, 32'h0080_0000, 3, 1'b1, pend);
    check("lbu_wdata", rf_wdata, 32'h0000_0080);
    run_load(5'd9, 3'b001, 2'd2, 32'h8001_1234, 2, 1'b1, pend);
    check("lh_wdata", rf_wdata, 32'hFFFF_8001);
    run_load(5'd9, 3'b101, 2'd2, 32'h8001_1234, 1, 1'b1, pend);
    check("lhu_wdata", rf_wdata, 32'h0000_8001);
    run_load(5'd10, 3'b010, 2'd0, 32'hDEAD_BEEF, 4, 1'b1, pend);
    check("lw_wdata", rf_wdata, 32'hDEAD_BEEF);
    run_load(5'd0, 3'b010, 2'd0, 32'h0BAD_0BAD, 2, 1'b1, pend);
    check("ld_rd0_wen", 32'(rf_wen), 32'd0);

    run_load(5'd11, 3'b010, 2'd0, 32'h5555_AAAA, TMO, 1'b1, pend);
    check("late_pend_cycles", 32'(pend), 32'(TMO));
    check("late_wen", 32'(rf_wen), 32'd1);
    check("late_wdata", rf_wdata, 32'h5555_AAAA);
    check("late_timeout_err", 32'(timeout_err), 32'd0);
    run_load(5'd12, 3'b010, 2'd0, 32'h0, TMO, 1'b0, pend);
    check("tmo_pend_cycles", 32'(pend), 32'(TMO));
    check("tmo_err", 32'(timeout_err), 32'd1);
    check("tmo_ready", 32'(in_ready), 32'd1);
    check("tmo_wen", 32'(rf_wen), 32'd0);

    issue_one(5'd4, 1'b1, 3'b011, 2'd1, 32'h0);
    check("f3_err", 32'(funct3_err), 32'd1);
    check("f3_prec_mis", 32'(misalign_err), 32'd0);
    issue_one(5'd4, 1'b1, 3'b001, 2'd1, 32'h0);
    check("mis_err", 32'(misalign_err), 32'd1);
    check("mis_ready", 32'(in_ready), 32'd1);
    check("mis_wen", 32'(rf_wen), 32'd0);
    issue_one(5'd4, 1'b1, 3'b010, 2'd2, 32'h0);
    check("f3_sticky", 32'(funct3_err), 32'd1);

    // Reset in the middle of a load, then a stray response.
    set_in(1'b1, 5'd7, 1'b1, 3'b010, 2'd0, 32'h0);
    @(posedge clock); #1;
    set_in(1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    mem_rvalid = 1'b0;
    @(negedge clock);
    check("wrst_wen", 32'(rf_wen), 32'd0);
    check("wrst_waddr", 32'(rf_waddr), 32'd0);
    check("wrst_wdata", rf_wdata, 32'd0);
    check("wrst_pending", {26'd0, pending_valid, pending_rd}, 32'd0);
    check("wrst_errs", {29'd0, misalign_err, funct3_err, timeout_err}, 32'd0);
    check("wrst_ready", 32'(in_ready), 32'd1);

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
